// File: rtl/reg_bank_scan_4x16.sv
// Four-entry register bank feeding a 4:1 mux stage, with a sequencer that
// scans the mux selects through every entry on a start pulse.
module reg_bank_scan_4x16 #(
    parameter int unsigned     WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int unsigned     HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic             s0,
    output logic             s1,
    output logic             scan_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DWELL_W    = 4;
    localparam int unsigned NUM_REGS   = 4;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         idx;
    logic [DWELL_W-1:0] dwell;
    logic [WIDTH-1:0]   regs [NUM_REGS];

    assign d0 = regs[0];
    assign d1 = regs[1];
    assign d2 = regs[2];
    assign d3 = regs[3];
    // idx is a register, so the selects stay glitch-free; {s0,s1} == idx.
    assign s0 = idx[1];
    assign s1 = idx[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= RESET_VAL;
            end
            state      <= IDLE;
            idx        <= 2'd0;
            dwell      <= '0;
            scan_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (we) begin
                regs[waddr] <= wdata;
            end
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SCAN;
                        idx        <= 2'd0;
                        dwell      <= '0;
                        scan_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    // Abort takes priority over the final step into DONE.
                    if (abort) begin
                        state      <= IDLE;
                        idx        <= 2'd0;
                        dwell      <= '0;
                        scan_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (idx == 2'd3) begin
                            state      <= DONE;
                            idx        <= 2'd0;
                            scan_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + DWELL_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    idx        <= 2'd0;
                    dwell      <= '0;
                    scan_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_scan_4x16.sv
// Directed bench for reg_bank_scan_4x16: one instance with HOLD_CYCLES=1 and
// one with HOLD_CYCLES=3, sharing the same stimulus.
module tb_reg_bank_scan_4x16;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         we = 1'b0;
    logic [1:0]   waddr = 2'd0;
    logic [W-1:0] wdata = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;

    logic [W-1:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
    logic         a_s0, a_s1, a_sv, a_busy, a_done;
    logic         b_s0, b_s1, b_sv, b_busy, b_done;
    logic [W-1:0] a_y, b_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_bank_scan_4x16 #(.WIDTH(W), .RESET_VAL(16'h0000), .HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .start(start), .abort(abort),
        .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3),
        .s0(a_s0), .s1(a_s1), .scan_valid(a_sv), .busy(a_busy), .done(a_done)
    );

    reg_bank_scan_4x16 #(.WIDTH(W), .RESET_VAL(16'h0000), .HOLD_CYCLES(3)) u_h3 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .start(start), .abort(abort),
        .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3),
        .s0(b_s0), .s1(b_s1), .scan_valid(b_sv), .busy(b_busy), .done(b_done)
    );

    // Downstream 4:1 mux stage: index {s0,s1} selects dk.
    always_comb begin
        case ({a_s0, a_s1})
            2'd0:    a_y = a_d0;
            2'd1:    a_y = a_d1;
            2'd2:    a_y = a_d2;
            default: a_y = a_d3;
        endcase
        case ({b_s0, b_s1})
            2'd0:    b_y = b_d0;
            2'd1:    b_y = b_d1;
            2'd2:    b_y = b_d2;
            default: b_y = b_d3;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((a_busy || b_busy) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (a_busy || b_busy) begin
            errors++;
            $display("FAIL wait_idle: busy h1=%b h3=%b required 0 within 60 cycles", a_busy, b_busy);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({a_d0, a_d1, a_d2, a_d3} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h required 0000 each", a_d0, a_d1, a_d2, a_d3);
        end
        checks++;
        if ({a_s0, a_s1, a_sv, a_busy, a_done, b_s0, b_s1, b_sv, b_busy, b_done} !== 10'b0) begin
            errors++;
            $display("FAIL reset_flags: h1 s=%b%b sv=%b busy=%b done=%b h3 s=%b%b sv=%b busy=%b done=%b required all 0",
                     a_s0, a_s1, a_sv, a_busy, a_done, b_s0, b_s1, b_sv, b_busy, b_done);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [W-1:0] vals [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
        logic [W-1:0] got;
        for (int k = 0; k < 4; k++) begin
            we = 1'b1;
            waddr = 2'(k);
            wdata = vals[k];
            tick();
            we = 1'b0;
            case (k)
                0: got = a_d0;
                1: got = a_d1;
                2: got = b_d2;
                default: got = b_d3;
            endcase
            checks++;
            if (got !== vals[k]) begin
                errors++;
                $display("FAIL write_d%0d: got %h required %h", k, got, vals[k]);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [W-1:0] vals [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({a_s0, a_s1} !== 2'(k) || a_sv !== 1'b1 || a_busy !== 1'b1 || a_y !== vals[k]) begin
                errors++;
                $display("FAIL basic_idx%0d: s=%b%b sv=%b busy=%b y=%h required s=%0d sv=1 busy=1 y=%h",
                         k, a_s0, a_s1, a_sv, a_busy, a_y, k, vals[k]);
            end
            tick();
        end
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b1 || a_sv !== 1'b0 || {a_s0, a_s1} !== 2'b00) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b sv=%b s=%b%b required done=1 busy=1 sv=0 s=00",
                     a_done, a_busy, a_sv, a_s0, a_s1);
        end
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b done=%b required 0 0", a_busy, a_done);
        end
        wait_idle();
    endtask

    task automatic test_dwell();
        logic [W-1:0] vals [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if ({b_s0, b_s1} !== 2'(c / 3) || b_sv !== 1'b1 || b_done !== 1'b0 || b_y !== vals[c / 3]) begin
                errors++;
                $display("FAIL dwell_cyc%0d: s=%b%b sv=%b done=%b y=%h required s=%0d sv=1 done=0 y=%h",
                         c, b_s0, b_s1, b_sv, b_done, b_y, c / 3, vals[c / 3]);
            end
            tick();
        end
        checks++;
        if (b_done !== 1'b1 || b_sv !== 1'b0 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL dwell_done: done=%b sv=%b busy=%b required 1 0 1", b_done, b_sv, b_busy);
        end
        tick();
        checks++;
        if (b_busy !== 1'b0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL dwell_idle: busy=%b done=%b required 0 0", b_busy, b_done);
        end
        wait_idle();
    endtask

    task automatic test_write_during_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        checks++;
        if ({b_s0, b_s1} !== 2'd2 || b_y !== 16'hC003) begin
            errors++;
            $display("FAIL wscan_first: s=%b%b y=%h required s=10 y=c003", b_s0, b_s1, b_y);
        end
        we = 1'b1;
        waddr = 2'd2;
        wdata = 16'h1234;
        tick();
        we = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({b_s0, b_s1} !== 2'd2 || b_sv !== 1'b1 || b_y !== 16'h1234) begin
                errors++;
                $display("FAIL wscan_after%0d: s=%b%b sv=%b y=%h required s=10 sv=1 y=1234",
                         c, b_s0, b_s1, b_sv, b_y);
            end
            tick();
        end
        checks++;
        if ({b_s0, b_s1} !== 2'd3 || b_y !== 16'hD004) begin
            errors++;
            $display("FAIL wscan_next: s=%b%b y=%h required s=11 y=d004", b_s0, b_s1, b_y);
        end
        wait_idle();
    endtask

    task automatic test_abort();
        int done_seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        // h3 sits at index 1; h1 is on its last index.
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({b_s0, b_s1} !== 2'd1 || b_sv !== 1'b1) begin
            errors++;
            $display("FAIL abort_start_ignored: s=%b%b sv=%b required s=01 sv=1", b_s0, b_s1, b_sv);
        end
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL abort_h1_done: done=%b required 1", a_done);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (b_sv !== 1'b0 || {b_s0, b_s1} !== 2'b00 || b_busy !== 1'b0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: sv=%b s=%b%b busy=%b done=%b required 0 00 0 0",
                     b_sv, b_s0, b_s1, b_busy, b_done);
        end
        repeat (14) begin
            tick();
            if (b_done || b_busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d cycles with done/busy, required 0", done_seen);
        end
    endtask

    task automatic test_abort_at_last();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_sv !== 1'b0) begin
            errors++;
            $display("FAIL abort_last: done=%b busy=%b sv=%b required 0 0 0", a_done, a_busy, a_sv);
        end
        wait_idle();
    endtask

    task automatic test_async_reset();
        int done_seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (b_sv !== 1'b0 || {b_s0, b_s1} !== 2'b00 || b_busy !== 1'b0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL areset_flags: sv=%b s=%b%b busy=%b done=%b required 0 00 0 0",
                     b_sv, b_s0, b_s1, b_busy, b_done);
        end
        checks++;
        if ({b_d0, b_d1, b_d2, b_d3} !== 64'h0) begin
            errors++;
            $display("FAIL areset_data: got %h %h %h %h required 0000 each", b_d0, b_d1, b_d2, b_d3);
        end
        #1;
        rst = 1'b0;
        repeat (15) begin
            tick();
            if (b_done || b_busy || a_done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL areset_no_done: %0d cycles with done/busy, required 0", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_basic_scan();
        test_dwell();
        test_write_during_scan();
        test_abort();
        test_abort_at_last();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
